cc_miss_issue_ctrl: RTL



---
 rtl/cc_pkg.sv | 26 ++
 rtl/cc_miss_issue_ctrl_if.sv | 40 ++++
 rtl/cc_miss_issue_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the cache-controller slice.
//   BURST_*        : AXI AxBURST encodings
//   LINE_BEATS     : data beats per cache-line refill
//   BEAT_SIZE      : AxSIZE for one 8-byte beat
//   LINE_OFFSET_W  : byte-offset width of a 64-byte line
//   state_e        : miss-issue FSM states
package cc_pkg;

  localparam logic [1:0]  BURST_FIXED   = 2'b00;
  localparam logic [1:0]  BURST_INCR    = 2'b01;
  localparam logic [1:0]  BURST_WRAP    = 2'b10;

  localparam int unsigned LINE_BEATS    = 8;
  localparam logic [2:0]  BEAT_SIZE     = 3'd3;
  localparam int unsigned LINE_OFFSET_W = 6;

  // AxLEN is beats minus one.
  localparam logic [3:0]  LINE_ARLEN    = 4'(LINE_BEATS - 1);
  localparam logic [2:0]  LAST_BEAT     = 3'(LINE_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } state_e;

endpackage

// File: rtl/cc_miss_issue_ctrl_if.sv
// Miss-issue bus bundle: miss-request FIFO read side, memory AR channel
// and the observed memory R handshake.
//   master : the miss-issue controller (pops the FIFO, drives AR)
//   slave  : the environment (FIFO, memory AR port, R-path observer)
interface cc_miss_issue_ctrl_if;
  // miss-request FIFO (show-ahead)
  logic        req_empty_i;
  logic [31:0] req_rdata_i;
  logic        req_rden_o;
  // memory AR channel
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  // memory R handshake, observed only
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;

  modport master (
    input  req_empty_i, req_rdata_i,
    output req_rden_o,
    output mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
           mem_arburst_o, mem_arvalid_o,
    input  mem_arready_i,
    input  mem_rvalid_i, mem_rready_i, mem_rlast_i
  );

  modport slave (
    output req_empty_i, req_rdata_i,
    input  req_rden_o,
    input  mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
           mem_arburst_o, mem_arvalid_o,
    output mem_arready_i,
    output mem_rvalid_i, mem_rready_i, mem_rlast_i
  );
endinterface

// File: rtl/cc_miss_issue_ctrl.sv
// Miss-issue controller: pops miss requests from the show-ahead FIFO and
// issues one 8-beat WRAP read burst per miss on the memory AR channel,
// caps in-flight bursts, retires bursts on observed rlast and flags R-side
// protocol violations.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   enable_i       : low blocks new pops; in-flight work completes
//   bus (master)   : FIFO pop, AR channel, observed R handshake
//   outstanding_o  : bursts accepted on AR and not yet retired
//   line_done_o    : one-cycle pulse per retired burst
//   proto_err_o    : sticky R-side protocol error
module cc_miss_issue_ctrl
  import cc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [3:0]  ARID            = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  cc_miss_issue_ctrl_if.master bus,
  output logic [2:0]           outstanding_o,
  output logic                 line_done_o,
  output logic                 proto_err_o
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  out_q, out_d;
  logic [2:0]  beat_q, beat_d;
  logic        line_done_q, line_done_d;
  logic        err_q, err_d;

  logic pop;
  logic ar_hs;
  logic r_hs;
  logic retire;

  always_comb begin
    // Gate uses the pre-update count, so a same-cycle retire at the cap
    // does not open a pop slot until the following cycle.
    pop    = (state_q == IDLE) && enable_i && !bus.req_empty_i
             && (out_q < MAX_OUT);
    ar_hs  = arvalid_q && bus.mem_arready_i;
    r_hs   = bus.mem_rvalid_i && bus.mem_rready_i;
    // An rlast with nothing in flight is an error, never a retire.
    retire = r_hs && bus.mem_rlast_i && (out_q != '0);

    state_d     = state_q;
    arvalid_d   = arvalid_q;
    addr_d      = addr_q;
    out_d       = out_q;
    beat_d      = beat_q;
    line_done_d = retire;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          addr_d    = {bus.req_rdata_i[31:3], 3'b000};
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    unique case ({ar_hs, retire})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase

    if (r_hs) begin
      beat_d = beat_q + 3'd1;
      if ((bus.mem_rlast_i && (beat_q != LAST_BEAT)) ||
          (!bus.mem_rlast_i && (beat_q == LAST_BEAT)) ||
          (bus.mem_rlast_i && (out_q == '0))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      out_q       <= '0;
      beat_q      <= '0;
      line_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      beat_q      <= beat_d;
      line_done_q <= line_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_rden_o    = pop;
  assign bus.mem_arid_o    = ARID;
  assign bus.mem_araddr_o  = addr_q;
  assign bus.mem_arlen_o   = LINE_ARLEN;
  assign bus.mem_arsize_o  = BEAT_SIZE;
  assign bus.mem_arburst_o = BURST_WRAP;
  assign bus.mem_arvalid_o = arvalid_q;

  assign outstanding_o = out_q;
  assign line_done_o   = line_done_q;
  assign proto_err_o   = err_q;

endmodule
